pulse_channel1: RTL and testbench

PULSE_CHANNEL1 -- requirements
Module: pulse_channel1

---
 rtl/pulse_channel1.sv | 185 ++++++++++++++++++
 tb/tb_pulse_channel1.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_channel1.sv
// Square-wave channel with duty table, length counter, frequency sweep and
// volume envelope. Frame-sequencer inputs are edge-detected in the clk domain.
module pulse_channel1 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk256,
    input  logic        clk128,
    input  logic        clk64,
    input  logic [2:0]  swpPd,
    input  logic        negate,
    input  logic [2:0]  shift,
    input  logic [10:0] freq,
    input  logic [5:0]  lenLoad,
    input  logic        lenEnable,
    input  logic [1:0]  duty,
    input  logic [3:0]  startVol,
    input  logic        envAdd,
    input  logic [2:0]  period,
    input  logic        trigger,
    output logic [3:0]  out
);

    logic        enabled_q, enabled_d;
    logic [6:0]  len_cnt_q, len_cnt_d;
    logic [3:0]  volume_q, volume_d;
    logic [2:0]  env_timer_q, env_timer_d;
    logic [3:0]  sweep_timer_q, sweep_timer_d;
    logic [10:0] shadow_q, shadow_d;
    logic        sweep_on_q, sweep_on_d;
    logic [2:0]  duty_step_q, duty_step_d;
    logic [13:0] freq_timer_q, freq_timer_d;
    logic        c256_q, c128_q, c64_q, trig_q;
    // Blocks a trigger held high through reset release from counting as an event
    logic        armed_q, armed_d;
    logic [3:0]  out_q, out_d;

    logic        trig_ev, tick256, tick128, tick64;
    logic [11:0] sweep_new, sweep_chk;
    logic        duty_bit;

    function automatic logic [11:0] sweep_calc(input logic [10:0] s, input logic [2:0] sh,
                                               input logic neg);
        logic [11:0] delta;
        delta = {1'b0, s >> sh};
        return neg ? ({1'b0, s} - delta) : ({1'b0, s} + delta);
    endfunction

    function automatic logic [13:0] freq_reload(input logic [10:0] s);
        logic [13:0] t;
        t = 14'd2048 - {3'd0, s};
        return t << 2;
    endfunction

    assign trig_ev = trigger & ~trig_q & armed_q;
    assign tick256 = clk256 & ~c256_q;
    assign tick128 = clk128 & ~c128_q;
    assign tick64  = clk64 & ~c64_q;

    // Next-state for all channel counters; a trigger pre-empts any frame tick
    always_comb begin
        enabled_d     = enabled_q;
        len_cnt_d     = len_cnt_q;
        volume_d      = volume_q;
        env_timer_d   = env_timer_q;
        sweep_timer_d = sweep_timer_q;
        shadow_d      = shadow_q;
        sweep_on_d    = sweep_on_q;
        duty_step_d   = duty_step_q;
        freq_timer_d  = freq_timer_q;
        armed_d       = armed_q | ~trigger;
        sweep_new     = sweep_calc(shadow_q, shift, negate);
        sweep_chk     = 12'd0;

        if (trig_ev) begin
            enabled_d     = 1'b1;
            len_cnt_d     = 7'd64 - {1'b0, lenLoad};
            volume_d      = startVol;
            env_timer_d   = period;
            shadow_d      = freq;
            freq_timer_d  = freq_reload(freq);
            duty_step_d   = 3'd0;
            sweep_timer_d = (swpPd == 3'd0) ? 4'd8 : {1'b0, swpPd};
            sweep_on_d    = (swpPd != 3'd0) || (shift != 3'd0);
            sweep_chk     = sweep_calc(freq, shift, negate);
            if ((shift != 3'd0) && (sweep_chk > 12'd2047)) enabled_d = 1'b0;
        end else begin
            if (freq_timer_q <= 14'd1) begin
                freq_timer_d = freq_reload(shadow_q);
                duty_step_d  = duty_step_q + 3'd1;
            end else begin
                freq_timer_d = freq_timer_q - 14'd1;
            end

            if (!sweep_on_q) shadow_d = freq;

            if (tick256 && lenEnable && (len_cnt_q != 7'd0)) begin
                len_cnt_d = len_cnt_q - 7'd1;
                if (len_cnt_q == 7'd1) enabled_d = 1'b0;
            end

            if (tick128) begin
                if (sweep_timer_q <= 4'd1) begin
                    sweep_timer_d = (swpPd == 3'd0) ? 4'd8 : {1'b0, swpPd};
                    if (sweep_on_q && (swpPd != 3'd0)) begin
                        if (sweep_new > 12'd2047) begin
                            enabled_d = 1'b0;
                        end else if (shift != 3'd0) begin
                            shadow_d  = sweep_new[10:0];
                            sweep_chk = sweep_calc(sweep_new[10:0], shift, negate);
                            if (sweep_chk > 12'd2047) enabled_d = 1'b0;
                        end
                    end
                end else begin
                    sweep_timer_d = sweep_timer_q - 4'd1;
                end
            end

            if (tick64 && (period != 3'd0)) begin
                if (env_timer_q <= 3'd1) begin
                    env_timer_d = period;
                    if (envAdd && (volume_q != 4'd15)) volume_d = volume_q + 4'd1;
                    else if (!envAdd && (volume_q != 4'd0)) volume_d = volume_q - 4'd1;
                end else begin
                    env_timer_d = env_timer_q - 3'd1;
                end
            end
        end

        // DAC powered down: channel can never be enabled
        if ((startVol == 4'd0) && !envAdd) enabled_d = 1'b0;
    end

    // Duty waveform lookup and registered sample
    always_comb begin
        duty_bit = 1'b0;
        unique case (duty)
            2'b00: duty_bit = (duty_step_q == 3'd7);
            2'b01: duty_bit = (duty_step_q == 3'd0) || (duty_step_q == 3'd7);
            2'b10: duty_bit = (duty_step_q == 3'd0) || (duty_step_q >= 3'd5);
            2'b11: duty_bit = (duty_step_q >= 3'd1) && (duty_step_q <= 3'd6);
            default: duty_bit = 1'b0;
        endcase
        out_d = (enabled_q && duty_bit) ? volume_q : 4'd0;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            enabled_q     <= 1'b0;
            len_cnt_q     <= 7'd0;
            volume_q      <= 4'd0;
            env_timer_q   <= 3'd0;
            sweep_timer_q <= 4'd0;
            shadow_q      <= 11'd0;
            sweep_on_q    <= 1'b0;
            duty_step_q   <= 3'd0;
            freq_timer_q  <= 14'd0;
            c256_q        <= 1'b0;
            c128_q        <= 1'b0;
            c64_q         <= 1'b0;
            trig_q        <= 1'b0;
            armed_q       <= 1'b0;
            out_q         <= 4'd0;
        end else begin
            enabled_q     <= enabled_d;
            len_cnt_q     <= len_cnt_d;
            volume_q      <= volume_d;
            env_timer_q   <= env_timer_d;
            sweep_timer_q <= sweep_timer_d;
            shadow_q      <= shadow_d;
            sweep_on_q    <= sweep_on_d;
            duty_step_q   <= duty_step_d;
            freq_timer_q  <= freq_timer_d;
            c256_q        <= clk256;
            c128_q        <= clk128;
            c64_q         <= clk64;
            trig_q        <= trigger;
            armed_q       <= armed_d;
            out_q         <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_pulse_channel1.sv
// Scoreboard bench for pulse_channel1: stimulus pushes the expected sample for
// each clock edge, a negedge monitor pops and compares.
module tb_pulse_channel1;

    logic        clk = 1'b0;
    logic        rst, clk256, clk128, clk64;
    logic [2:0]  swpPd, shift, period;
    logic        negate, lenEnable, envAdd, trigger;
    logic [10:0] freq;
    logic [5:0]  lenLoad;
    logic [1:0]  duty;
    logic [3:0]  startVol, out;

    always #5 clk = ~clk;

    pulse_channel1 dut (
        .clk(clk), .rst(rst), .clk256(clk256), .clk128(clk128), .clk64(clk64),
        .swpPd(swpPd), .negate(negate), .shift(shift), .freq(freq),
        .lenLoad(lenLoad), .lenEnable(lenEnable), .duty(duty), .startVol(startVol),
        .envAdd(envAdd), .period(period), .trigger(trigger), .out(out)
    );

    typedef struct {
        logic [3:0] exp;
        int         tid;
        int         k;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_it;
    int    n_checks = 0;
    int    n_fails  = 0;
    int    cur_tid  = 0;
    int    cur_k    = 0;
    string tname[11] = '{"reset", "held_trig", "duty", "length", "envelope", "sweep_ovf",
                         "sweep_neg", "mid_reset", "trig_tick", "dac_off", "env_up"};

    // Monitor: one comparison per queued expectation
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_it = sb_q.pop_front();
            n_checks++;
            if (out !== mon_it.exp) begin
                n_fails++;
                $display("FAIL out %s k=%0d got=%0d want=%0d", tname[mon_it.tid], mon_it.k,
                         out, mon_it.exp);
            end
        end
    end

    // Apply current inputs at the next edge and expect e on out afterwards
    task automatic tick(input logic [3:0] e);
        exp_t it;
        @(posedge clk);
        #1;
        it.exp = e;
        it.tid = cur_tid;
        it.k   = cur_k;
        sb_q.push_back(it);
    endtask

    function automatic bit duty_hi(input logic [1:0] d, input int s);
        case (d)
            2'd0:    return s == 7;
            2'd1:    return (s == 0) || (s == 7);
            2'd2:    return (s == 0) || (s >= 5);
            default: return (s >= 1) && (s <= 6);
        endcase
    endfunction

    // Expected out k edges after a trigger for a 4-clk step (freq=2047)
    function automatic logic [3:0] pat(input logic [1:0] d, input int k, input logic [3:0] v);
        if (k == 0) return 4'd0;
        return duty_hi(d, ((k - 1) / 4) % 8) ? v : 4'd0;
    endfunction

    // Volume after edge m with clk64 ticks at edges 34, 66, 98, ...
    function automatic logic [3:0] vol_after(input int m);
        int n;
        if (m < 34) return 4'd15;
        n = (m - 2) / 32;
        return (n >= 15) ? 4'd0 : 4'(15 - n);
    endfunction

    task automatic set_defaults();
        freq = 11'd2047; duty = 2'd2; startVol = 4'd15; envAdd = 1'b0; period = 3'd0;
        lenEnable = 1'b0; lenLoad = 6'd0; swpPd = 3'd0; shift = 3'd0; negate = 1'b0;
        clk256 = 1'b0; clk128 = 1'b0; clk64 = 1'b0;
    endtask

    task automatic do_reset();
        cur_k = -1;
        rst = 1'b1; trigger = 1'b0;
        tick(4'd0); tick(4'd0);
        rst = 1'b0;
        tick(4'd0);
    endtask

    initial begin
        set_defaults();
        rst = 1'b1; trigger = 1'b0;

        // Reset then idle: silent
        cur_tid = 0; cur_k = -1;
        tick(4'd0); tick(4'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick(4'd0);

        // Trigger held high through reset release is not an event
        cur_tid = 1;
        rst = 1'b1; trigger = 1'b1;
        tick(4'd0); tick(4'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick(4'd0);

        // All four duty patterns, 4 clk per step
        cur_tid = 2;
        for (int d = 0; d < 4; d++) begin
            set_defaults();
            duty = 2'(d);
            do_reset();
            trigger = 1'b1;
            for (int k = 0; k < 70; k++) begin
                cur_k = k;
                tick(pat(2'(d), k, 4'd15));
            end
        end

        // Length 62 -> silent after second clk256 tick
        cur_tid = 3;
        set_defaults();
        lenEnable = 1'b1; lenLoad = 6'd62;
        do_reset();
        trigger = 1'b1;
        for (int k = 0; k < 121; k++) begin
            cur_k = k;
            clk256 = (k == 40) || (k == 80);
            tick((k <= 80) ? pat(2'd2, k, 4'd15) : 4'd0);
        end

        // Envelope decay, one step per clk64 tick, saturating at 0
        cur_tid = 4;
        set_defaults();
        duty = 2'd3; period = 3'd1;
        do_reset();
        trigger = 1'b1;
        for (int k = 0; k <= 600; k++) begin
            cur_k = k;
            clk64 = (k >= 34) && (((k - 2) % 32) == 0);
            tick((k == 0) ? 4'd0 : (duty_hi(2'd3, ((k - 1) / 4) % 8) ? vol_after(k - 1) : 4'd0));
        end

        // Sweep add overflows at trigger: silent
        cur_tid = 5;
        set_defaults();
        freq = 11'd2000; shift = 3'd1; swpPd = 3'd1;
        do_reset();
        trigger = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cur_k = k;
            tick(4'd0);
        end

        // Sweep subtract: shadow 2000 -> 1000, step becomes 4192 clk
        cur_tid = 6;
        negate = 1'b1;
        do_reset();
        trigger = 1'b1;
        for (int k = 0; k <= 16980; k++) begin
            cur_k = k;
            clk128 = (k == 10);
            tick((k == 0) ? 4'd0 : (k <= 192) ? 4'd15 : (k <= 16960) ? 4'd0 : 4'd15);
        end

        // Reset mid-note overrides a simultaneous trigger and tick
        cur_tid = 7;
        set_defaults();
        do_reset();
        trigger = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cur_k = k;
            tick(pat(2'd2, k, 4'd15));
        end
        cur_k = 3; trigger = 1'b0;
        tick(4'd15);
        cur_k = 4; rst = 1'b1; trigger = 1'b1; clk64 = 1'b1; clk256 = 1'b1;
        tick(4'd0);
        cur_k = 5; rst = 1'b0;
        for (int i = 0; i < 8; i++) tick(4'd0);

        // Trigger coincident with clk256 tick: length 1 not consumed
        cur_tid = 8;
        set_defaults();
        lenEnable = 1'b1; lenLoad = 6'd63;
        do_reset();
        trigger = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cur_k = k;
            clk256 = (k == 0);
            tick(pat(2'd2, k, 4'd15));
        end

        // DAC off
        cur_tid = 9;
        set_defaults();
        duty = 2'd3; startVol = 4'd0; envAdd = 1'b0; period = 3'd1;
        do_reset();
        trigger = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cur_k = k;
            clk64 = (k == 2);
            tick(4'd0);
        end

        // startVol 0 with envelope up keeps DAC on
        cur_tid = 10;
        envAdd = 1'b1;
        do_reset();
        trigger = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cur_k = k;
            clk64 = (k == 2);
            tick((k <= 2) ? 4'd0 : (duty_hi(2'd3, ((k - 1) / 4) % 8) ? 4'd1 : 4'd0));
        end

        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
